// File: rtl/ram_pkg.sv
// Shared encodings for the wait-state RAM: access sizes, controller states
// and the wait counter width.
package ram_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // A fault is a reserved size or an address not aligned to the access size.
   function automatic logic isMisaligned(input size_e size, input logic [1:0] addrLsb);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addrLsb[0];
         SZ_WORD: bad = |addrLsb;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] laneMask(input size_e size);
      logic [3:0] mask;
      case (size)
         SZ_BYTE: mask = 4'b0001;
         SZ_HALF: mask = 4'b0011;
         SZ_WORD: mask = 4'b1111;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/ram_byte_array.sv
// DEPTHx8 storage with one 4-lane byte-enabled write port and a combinational
// 4-lane read port; lane k addresses byte i_addr+k. Contents survive reset.
module ram_byte_array #(
   parameter int DEPTH = 256,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic [AW-1:0] i_addr,
   input  logic [3:0]    i_byteEn,
   input  logic [31:0]   i_wrData,
   output logic [31:0]   o_rdData
);

   logic [7:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      for (int k = 0; k < 4; k++) begin
         if (i_byteEn[k]) begin
            r_mem[i_addr + AW'(k)] <= i_wrData[8*k +: 8];
         end
      end
   end

   for (genvar k = 0; k < 4; k++) begin : g_rdLane
      assign o_rdData[8*k +: 8] = r_mem[i_addr + AW'(k)];
   end

endmodule

// File: rtl/ram_waitstate.sv
// Byte-addressed RAM behind a MOV/MOC handshake with a programmable number of
// wait states; handles byte/half/word steering, extension and alignment faults.
module ram_waitstate
   import ram_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2,
   parameter bit BIG_ENDIAN  = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        MOV,
   input  logic        ReadWrite,
   input  logic [2:0]  MS_2_0,
   input  logic [31:0] DataIn,
   input  logic [31:0] Address,
   output logic        MOC,
   output logic [31:0] DataOut,
   output logic        ALIGN_ERR
);

   localparam int AW = $clog2(DEPTH);

   state_e           r_state;
   state_e           w_nextState;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_nextCnt;

   logic             r_readWrite;
   size_e            r_size;
   logic             r_signed;
   logic [31:0]      r_dataIn;
   logic [AW-1:0]    r_addr;

   logic             r_moc;
   logic [31:0]      r_dataOut;
   logic             r_alignErr;

   logic             w_latch;
   logic             w_complete;
   logic             w_release;
   logic             w_misaligned;
   logic             w_wrFire;
   logic [3:0]       w_byteEn;
   logic [31:0]      w_wrLanes;
   logic [31:0]      w_rdLanes;
   logic [15:0]      w_half;
   logic [31:0]      w_word;
   logic [31:0]      w_rdValue;
   logic             w_unusedAddr;

   // High address bits alias onto the array and are deliberately dropped.
   assign w_unusedAddr = ^Address[31:AW];

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_latch     = 1'b0;
      w_complete  = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (MOV) begin
               w_latch     = 1'b1;
               w_nextCnt   = CNT_W'(WAIT_CYCLES);
               w_nextState = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!MOV) begin
               w_nextCnt   = '0;
               w_nextState = ST_IDLE;
            end else if (r_cnt == '0) begin
               w_complete  = 1'b1;
               w_nextState = ST_DONE;
            end else begin
               w_nextCnt = r_cnt - CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (!MOV) begin
               w_release   = 1'b1;
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextCnt   = '0;
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_moc      <= 1'b0;
         r_dataOut  <= '0;
         r_alignErr <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
         if (w_complete) begin
            r_moc      <= 1'b1;
            r_alignErr <= w_misaligned;
            if (w_misaligned) begin
               r_dataOut <= '0;
            end else if (r_readWrite) begin
               r_dataOut <= w_rdValue;
            end
         end else if (w_release) begin
            r_moc      <= 1'b0;
            r_alignErr <= 1'b0;
         end
      end
   end

   // Request fields are captured once so the bus may move on during the wait.
   always_ff @(posedge CLK) begin
      if (w_latch && !RESET) begin
         r_readWrite <= ReadWrite;
         r_size      <= size_e'(MS_2_0[1:0]);
         r_signed    <= MS_2_0[2];
         r_dataIn    <= DataIn;
         r_addr      <= Address[AW-1:0];
      end
   end

   assign w_misaligned = isMisaligned(r_size, r_addr[1:0]);

   always_comb begin
      w_half    = BIG_ENDIAN ? {w_rdLanes[7:0], w_rdLanes[15:8]} : w_rdLanes[15:0];
      w_word    = BIG_ENDIAN ? {w_rdLanes[7:0], w_rdLanes[15:8], w_rdLanes[23:16], w_rdLanes[31:24]}
                             : w_rdLanes;
      w_rdValue = '0;
      case (r_size)
         SZ_BYTE: w_rdValue = {{24{r_signed & w_rdLanes[7]}}, w_rdLanes[7:0]};
         SZ_HALF: w_rdValue = {{16{r_signed & w_half[15]}}, w_half};
         SZ_WORD: w_rdValue = w_word;
         default: w_rdValue = '0;
      endcase
   end

   // Lane 0 always holds the byte at the base address.
   always_comb begin
      w_wrLanes = '0;
      case (r_size)
         SZ_BYTE: w_wrLanes = {24'd0, r_dataIn[7:0]};
         SZ_HALF: w_wrLanes = BIG_ENDIAN ? {16'd0, r_dataIn[7:0], r_dataIn[15:8]}
                                         : {16'd0, r_dataIn[15:0]};
         SZ_WORD: w_wrLanes = BIG_ENDIAN ? {r_dataIn[7:0], r_dataIn[15:8], r_dataIn[23:16], r_dataIn[31:24]}
                                         : r_dataIn;
         default: w_wrLanes = '0;
      endcase
   end

   assign w_wrFire = w_complete & ~r_readWrite & ~w_misaligned & ~RESET;
   assign w_byteEn = laneMask(r_size) & {4{w_wrFire}};

   ram_byte_array #(
      .DEPTH(DEPTH)
   ) u_array (
      .i_clk   (CLK),
      .i_addr  (r_addr),
      .i_byteEn(w_byteEn),
      .i_wrData(w_wrLanes),
      .o_rdData(w_rdLanes)
   );

   assign MOC       = r_moc;
   assign DataOut   = r_dataOut;
   assign ALIGN_ERR = r_alignErr;

endmodule

// File: tb/tb_ram_waitstate.sv
// Directed plus randomized bench for ram_waitstate: a big-endian 256-byte, 2-wait
// instance and a little-endian 16-byte, zero-wait instance against a byte-array model.
module tb_ram_waitstate;

   logic        clk;
   logic        reset;
   logic        mov1;
   logic        mov0;
   logic        readWrite;
   logic [2:0]  ms;
   logic [31:0] dataIn;
   logic [31:0] address;
   logic        moc1;
   logic        moc0;
   logic [31:0] dataOut1;
   logic [31:0] dataOut0;
   logic        alignErr1;
   logic        alignErr0;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem1 [256];
   logic [7:0]  mem0 [16];
   logic [31:0] expDout1 = '0;
   logic [31:0] expDout0 = '0;
   logic [7:0]  origByte0;

   ram_waitstate #(.DEPTH(256), .WAIT_CYCLES(2), .BIG_ENDIAN(1'b1)) dut (
      .CLK(clk), .RESET(reset), .MOV(mov1), .ReadWrite(readWrite), .MS_2_0(ms),
      .DataIn(dataIn), .Address(address), .MOC(moc1), .DataOut(dataOut1), .ALIGN_ERR(alignErr1)
   );

   ram_waitstate #(.DEPTH(16), .WAIT_CYCLES(0), .BIG_ENDIAN(1'b0)) dut0 (
      .CLK(clk), .RESET(reset), .MOV(mov0), .ReadWrite(readWrite), .MS_2_0(ms),
      .DataIn(dataIn), .Address(address), .MOC(moc0), .DataOut(dataOut0), .ALIGN_ERR(alignErr0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int sizeBytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
   endfunction

   function automatic bit modelMisaligned(input logic [1:0] sz, input logic [31:0] addr);
      return (sz == 2'b11) || (sz == 2'b01 && addr % 2 != 0) || (sz == 2'b10 && addr % 4 != 0);
   endfunction

   function automatic logic [7:0] memByte(input int sel, input int idx);
      return (sel != 0) ? mem1[idx % 256] : mem0[idx % 16];
   endfunction

   // Value = weighted sum of bytes; big-endian weights fall from the base address up.
   function automatic logic [31:0] modelRead(input int sel, input logic [2:0] msv, input logic [31:0] addr);
      int     n = sizeBytes(msv[1:0]);
      int     depth = (sel != 0) ? 256 : 16;
      int     base = int'(addr % depth);
      longint v = 0;
      for (int i = 0; i < n; i++) begin
         if (sel != 0) v = v * 256 + longint'(memByte(sel, base + i));
         else          v = v + (longint'(memByte(sel, base + i)) << (8 * i));
      end
      if (msv[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      return 32'(v);
   endfunction

   function automatic void modelWrite(input int sel, input logic [1:0] sz, input logic [31:0] din,
                                      input logic [31:0] addr);
      int n = sizeBytes(sz);
      int depth = (sel != 0) ? 256 : 16;
      int base = int'(addr % depth);
      int shift;
      for (int i = 0; i < n; i++) begin
         shift = (sel != 0) ? 8 * (n - 1 - i) : 8 * i;
         if (sel != 0) mem1[(base + i) % 256] = 8'(din >> shift);
         else          mem0[(base + i) % 16]  = 8'(din >> shift);
      end
   endfunction

   function automatic logic getMoc(input int sel);
      return (sel != 0) ? moc1 : moc0;
   endfunction

   function automatic logic [31:0] getDout(input int sel);
      return (sel != 0) ? dataOut1 : dataOut0;
   endfunction

   function automatic logic getErr(input int sel);
      return (sel != 0) ? alignErr1 : alignErr0;
   endfunction

   task automatic setMov(input int sel, input logic v);
      if (sel != 0) mov1 = v;
      else          mov0 = v;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic scrambleInputs();
      readWrite = 1'($urandom);
      ms        = 3'($urandom);
      dataIn    = $urandom;
      address   = $urandom;
   endtask

   // One full handshake; bus inputs are scrambled as soon as the request is latched.
   task automatic applyStimulus(input int sel, input logic rw, input logic [2:0] msv,
                                input logic [31:0] din, input logic [31:0] addr,
                                output logic [31:0] got);
      int          lat;
      logic        expErr;
      logic [31:0] expOut;
      expErr = modelMisaligned(msv[1:0], addr);
      if (expErr)  expOut = '0;
      else if (rw) expOut = modelRead(sel, msv, addr);
      else         expOut = (sel != 0) ? expDout1 : expDout0;
      @(negedge clk);
      readWrite = rw; ms = msv; dataIn = din; address = addr;
      setMov(sel, 1'b1);
      @(posedge clk); #1;
      scrambleInputs();
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         scrambleInputs();
      end while (!getMoc(sel) && lat < 40);
      checkOutput("latency", 32'(lat), (sel != 0) ? 32'd3 : 32'd1);
      checkOutput("dataOut", getDout(sel), expOut);
      checkOutput("alignErr", {31'd0, getErr(sel)}, {31'd0, expErr});
      got = getDout(sel);
      if (!expErr && !rw) modelWrite(sel, msv[1:0], din, addr);
      if (sel != 0) expDout1 = expOut;
      else          expDout0 = expOut;
      @(posedge clk); #1;
      checkOutput("holdMoc", {31'd0, getMoc(sel)}, 32'd1);
      checkOutput("holdData", getDout(sel), expOut);
      setMov(sel, 1'b0);
      @(posedge clk); #1;
      checkOutput("releaseMoc", {31'd0, getMoc(sel)}, 32'd0);
   endtask

   initial begin
      logic [31:0] got;
      logic [1:0]  sz;
      logic [31:0] addr;
      reset = 1'b1; mov1 = 1'b0; mov0 = 1'b0;
      readWrite = 1'b1; ms = 3'b000; dataIn = '0; address = '0;

      for (int i = 0; i < 256; i++) begin
         mem1[i] = 8'($urandom);
         dut.u_array.r_mem[i] = mem1[i];
      end
      for (int i = 0; i < 16; i++) begin
         mem0[i] = 8'($urandom);
         dut0.u_array.r_mem[i] = mem0[i];
      end
      mem1[5] = 8'h9C;
      dut.u_array.r_mem[5] = 8'h9C;

      mov1 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetMoc", {31'd0, moc1}, 32'd0);
      checkOutput("resetDout", dataOut1, 32'd0);
      checkOutput("resetErr", {31'd0, alignErr1}, 32'd0);
      checkOutput("resetMoc0", {31'd0, moc0}, 32'd0);
      mov1 = 1'b0;
      reset = 1'b0;

      applyStimulus(1, 1'b1, 3'b100, 32'd0, 32'd5, got);
      checkOutput("signedByte", got, 32'hFFFFFF9C);
      applyStimulus(1, 1'b1, 3'b000, 32'd0, 32'd5, got);
      checkOutput("unsignedByte", got, 32'h0000009C);

      applyStimulus(1, 1'b0, 3'b010, 32'hC0000001, 32'd12, got);
      applyStimulus(1, 1'b1, 3'b001, 32'd0, 32'd14, got);
      checkOutput("beHalf", got, 32'h00000001);
      applyStimulus(1, 1'b1, 3'b000, 32'd0, 32'd12, got);
      checkOutput("beByte", got, 32'h000000C0);

      applyStimulus(1, 1'b1, 3'b001, 32'd0, 32'd13, got);
      checkOutput("misalignDout", got, 32'd0);
      applyStimulus(1, 1'b1, 3'b010, 32'd0, 32'd12, got);
      checkOutput("afterFault", got, 32'hC0000001);

      origByte0 = mem1[0];
      @(negedge clk);
      readWrite = 1'b0; ms = 3'b000; dataIn = 32'hFF; address = 32'd0; mov1 = 1'b1;
      @(posedge clk); #1;
      mov1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checkOutput("abortMoc", {31'd0, moc1}, 32'd0);
      end
      applyStimulus(1, 1'b1, 3'b000, 32'd0, 32'd0, got);
      checkOutput("abortNoWrite", got, {24'd0, origByte0});

      applyStimulus(1, 1'b0, 3'b000, 32'h5A, 32'h100, got);
      applyStimulus(1, 1'b1, 3'b000, 32'd0, 32'h000, got);
      checkOutput("alias", got, 32'h5A);

      @(negedge clk);
      readWrite = 1'b0; ms = 3'b010; dataIn = 32'h12345678; address = 32'd40; mov1 = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      checkOutput("midResetMoc", {31'd0, moc1}, 32'd0);
      checkOutput("midResetDout", dataOut1, 32'd0);
      checkOutput("midResetDout0", dataOut0, 32'd0);
      reset = 1'b0; mov1 = 1'b0;
      expDout1 = '0; expDout0 = '0;
      repeat (4) begin
         @(posedge clk); #1;
         checkOutput("postResetMoc", {31'd0, moc1}, 32'd0);
      end
      applyStimulus(1, 1'b1, 3'b010, 32'd0, 32'd40, got);

      for (int t = 0; t < 80; t++) begin
         sz = ($urandom_range(0, 9) == 9) ? 2'b11 : 2'($urandom_range(0, 2));
         addr = $urandom;
         if ($urandom_range(0, 4) != 0) begin
            if (sz == 2'b01) addr[0] = 1'b0;
            if (sz == 2'b10) addr[1:0] = 2'b00;
         end
         applyStimulus(t % 2, 1'($urandom), {1'($urandom), sz}, $urandom, addr, got);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
